// File: rtl/pool_pkg.sv
// Shared state encoding and sizing helpers for the max-pool sequencing controller.
package pool_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FEED,
    S_DRAIN,
    S_CLR,
    S_DONE
  } state_t;

  function automatic int pix_per_ch(input int w, input int h);
    return w * h;
  endfunction

  function automatic int out_pix(input int w, input int h);
    return (w / 2) * (h / 2);
  endfunction

  // Bits needed to hold the values 0..n-1.
  function automatic int bits_for(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pool_addr_gen.sv
// Pixel/output counters and per-channel source/destination base accumulators.
module pool_addr_gen
  import pool_pkg::*;
#(
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28,
  parameter int ADDR_W = 16,
  localparam int PIX_PER_CH = pix_per_ch(IMG_W, IMG_H),
  localparam int OUT_PIX    = out_pix(IMG_W, IMG_H),
  localparam int PIX_W      = bits_for(PIX_PER_CH),
  localparam int OUT_W      = bits_for(OUT_PIX + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_run_clr,
  input  logic              i_pix_step,
  input  logic              i_out_step,
  input  logic              i_cnt_clr,
  input  logic              i_next_ch,
  output logic              o_pix_last,
  output logic [OUT_W-1:0]  o_out_cnt,
  output logic [ADDR_W-1:0] o_src_addr,
  output logic [ADDR_W-1:0] o_dst_addr
);

  logic [PIX_W-1:0]  r_pix;
  logic [OUT_W-1:0]  r_out_cnt;
  logic [ADDR_W-1:0] r_src_base;
  logic [ADDR_W-1:0] r_dst_base;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pix      <= '0;
      r_out_cnt  <= '0;
      r_src_base <= '0;
      r_dst_base <= '0;
    end else if (i_run_clr) begin
      r_pix      <= '0;
      r_out_cnt  <= '0;
      r_src_base <= '0;
      r_dst_base <= '0;
    end else begin
      if (i_cnt_clr) begin
        r_pix     <= '0;
        r_out_cnt <= '0;
      end else begin
        if (i_pix_step)
          r_pix <= o_pix_last ? '0 : r_pix + PIX_W'(1);
        if (i_out_step)
          r_out_cnt <= r_out_cnt + OUT_W'(1);
      end
      // Channel bases advance by accumulation so no multiplier is needed.
      if (i_next_ch) begin
        r_src_base <= r_src_base + ADDR_W'(PIX_PER_CH);
        r_dst_base <= r_dst_base + ADDR_W'(OUT_PIX);
      end
    end
  end

  assign o_pix_last = (r_pix == PIX_W'(PIX_PER_CH - 1));
  assign o_out_cnt  = r_out_cnt;
  assign o_src_addr = r_src_base + ADDR_W'(r_pix);
  assign o_dst_addr = r_dst_base + ADDR_W'(r_out_cnt);

endmodule

// File: rtl/max_pool_ctrl.sv
// Sequences NUM_CH feature maps through the 2x2 max-pool unit and packs its
// results into the destination buffer, flagging short/long output counts.
module max_pool_ctrl
  import pool_pkg::*;
#(
  parameter int IMG_W     = 28,
  parameter int IMG_H     = 28,
  parameter int MAX_CH    = 8,
  parameter int ADDR_W    = 16,
  parameter int DRAIN_MAX = 64,
  localparam int CH_W     = $clog2(MAX_CH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CH_W-1:0]   cfg_num_ch,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              src_rd_en,
  output logic [ADDR_W-1:0] src_rd_addr,
  input  logic [7:0]        src_rd_data,
  output logic [7:0]        pool_in_data,
  output logic              pool_in_valid,
  output logic              pool_clr,
  input  logic [7:0]        pool_out_data,
  input  logic              pool_out_valid,
  output logic              dst_wr_en,
  output logic [ADDR_W-1:0] dst_wr_addr,
  output logic [7:0]        dst_wr_data
);

  localparam int OUT_PIX = out_pix(IMG_W, IMG_H);
  localparam int OUT_W   = bits_for(OUT_PIX + 1);
  localparam int TMR_W   = bits_for(DRAIN_MAX);

  state_t            r_state, w_state_nxt;
  logic [CH_W-1:0]   r_num_ch, r_ch, w_num_ch_sat;
  logic [TMR_W-1:0]  r_timer;
  logic              r_err, r_rd_en_p1;
  logic              w_start_ok, w_active, w_wr, w_ovf, w_full_nxt;
  logic              w_timeout, w_last_ch, w_pix_last, w_next_ch;
  logic [OUT_W-1:0]  w_out_cnt;
  logic [ADDR_W-1:0] w_src_addr, w_dst_addr;

  assign w_start_ok   = (r_state == S_IDLE) && start;
  assign w_num_ch_sat = (cfg_num_ch > CH_W'(MAX_CH)) ? CH_W'(MAX_CH) : cfg_num_ch;
  assign w_active     = (r_state == S_FEED) || (r_state == S_DRAIN);
  assign w_wr         = w_active && pool_out_valid && (w_out_cnt != OUT_W'(OUT_PIX));
  assign w_ovf        = w_active && pool_out_valid && (w_out_cnt == OUT_W'(OUT_PIX));
  // An output landing in this cycle counts toward the DRAIN exit check.
  assign w_full_nxt   = (w_out_cnt == OUT_W'(OUT_PIX)) ||
                        (w_wr && (w_out_cnt == OUT_W'(OUT_PIX - 1)));
  assign w_timeout    = (r_timer == TMR_W'(DRAIN_MAX - 1));
  assign w_last_ch    = (r_ch == r_num_ch - CH_W'(1));

  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    src_rd_en   = 1'b0;
    pool_clr    = 1'b0;
    w_next_ch   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start)
          w_state_nxt = (w_num_ch_sat == '0) ? S_DONE : S_FEED;
      end
      S_FEED: begin
        busy      = 1'b1;
        src_rd_en = 1'b1;
        if (w_pix_last)
          w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (w_full_nxt || w_timeout)
          w_state_nxt = S_CLR;
      end
      S_CLR: begin
        busy     = 1'b1;
        pool_clr = 1'b1;
        if (w_last_ch) begin
          w_state_nxt = S_DONE;
        end else begin
          w_next_ch   = 1'b1;
          w_state_nxt = S_FEED;
        end
      end
      S_DONE: begin
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_num_ch   <= '0;
      r_ch       <= '0;
      r_timer    <= '0;
      r_err      <= 1'b0;
      r_rd_en_p1 <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_rd_en_p1 <= src_rd_en;
      r_timer    <= (r_state == S_DRAIN) ? r_timer + TMR_W'(1) : '0;
      if (w_start_ok) begin
        r_num_ch <= w_num_ch_sat;
        r_ch     <= '0;
        r_err    <= 1'b0;
      end else begin
        if (w_next_ch)
          r_ch <= r_ch + CH_W'(1);
        if (w_ovf || ((r_state == S_DRAIN) && w_timeout && !w_full_nxt))
          r_err <= 1'b1;
      end
    end
  end

  pool_addr_gen #(
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H),
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .clk        (clk),
    .rst        (rst),
    .i_run_clr  (w_start_ok),
    .i_pix_step (r_state == S_FEED),
    .i_out_step (w_wr),
    .i_cnt_clr  (r_state == S_CLR),
    .i_next_ch  (w_next_ch),
    .o_pix_last (w_pix_last),
    .o_out_cnt  (w_out_cnt),
    .o_src_addr (w_src_addr),
    .o_dst_addr (w_dst_addr)
  );

  // Read data returns one cycle after the strobe; the delayed strobe is its valid.
  assign src_rd_addr   = src_rd_en ? w_src_addr : '0;
  assign pool_in_valid = r_rd_en_p1;
  assign pool_in_data  = r_rd_en_p1 ? src_rd_data : 8'h00;
  assign dst_wr_en     = w_wr;
  assign dst_wr_addr   = w_wr ? w_dst_addr : '0;
  assign dst_wr_data   = w_wr ? pool_out_data : 8'h00;
  assign err           = r_err;

endmodule
